serial_addsub32: RTL

- Multi-cycle, bit-sliced adder/subtractor for 32-bit operands, with valid/ready handshakes on input and output.
- Processes STEP bits per cycle, LSB first, with a registered carry between slices.
- Complement of the combinational ripple adder: trades latency for area. Used where a single narrow adder slice is reused over time.
- Subtraction is implemented as a + ~b + 1.

---
 rtl/serial_addsub32_if.sv | 38 +++
 rtl/serial_addsub32.sv | 123 ++++++++++++
 2 files changed

// File: rtl/serial_addsub32_if.sv
// Handshake/operand bundle for serial_addsub32; zero_o/overflow_o exist only
// when SERIAL_ADDSUB_FLAGS_EN is defined.
interface serial_addsub32_if #(
    parameter int WIDTH = 32
);
    logic             valid_i;
    logic             ready_o;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             sub_i;
    logic             carry_i;
    logic             valid_o;
    logic             ready_i;
    logic [WIDTH-1:0] result_o;
    logic             carry_o;
`ifdef SERIAL_ADDSUB_FLAGS_EN
    logic             zero_o;
    logic             overflow_o;

    modport master (
        output valid_i, a_i, b_i, sub_i, carry_i, ready_i,
        input  ready_o, valid_o, result_o, carry_o, zero_o, overflow_o
    );
    modport slave (
        input  valid_i, a_i, b_i, sub_i, carry_i, ready_i,
        output ready_o, valid_o, result_o, carry_o, zero_o, overflow_o
    );
`else
    modport master (
        output valid_i, a_i, b_i, sub_i, carry_i, ready_i,
        input  ready_o, valid_o, result_o, carry_o
    );
    modport slave (
        input  valid_i, a_i, b_i, sub_i, carry_i, ready_i,
        output ready_o, valid_o, result_o, carry_o
    );
`endif
endinterface

// File: rtl/serial_addsub32.sv
// Bit-sliced adder/subtractor: STEP bits per cycle, LSB first, registered carry.
// Define SERIAL_ADDSUB_FLAGS_EN to add registered zero_o / overflow_o outputs.
//
// state  | meaning
// S_IDLE | ready for operands
// S_RUN  | processing one slice per cycle
// S_DONE | result presented, waiting for consumer
module serial_addsub32 #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    serial_addsub32_if.slave bus
);
    localparam int NSLICE = WIDTH / STEP;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

    generate
        if (WIDTH % STEP != 0) begin : g_step_check
            $error("serial_addsub32: STEP must divide WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_result;
    logic             r_carry;
    logic             r_carry_out;
    logic [STEP:0]    w_slice;
    logic [WIDTH-1:0] w_result_next;
    logic             w_accept;
    logic             w_last;
    logic             w_ack;

    assign w_accept = bus.valid_i && (r_state == S_IDLE);
    assign w_last   = (r_state == S_RUN) && (r_cnt == LAST);
    assign w_ack    = bus.ready_i && (r_state == S_DONE);

    assign w_slice = {1'b0, r_a[STEP-1:0]} + {1'b0, r_b[STEP-1:0]} + (STEP+1)'(r_carry);
    // New sum bits enter from the MSB side so the LSB slice lands at bit 0 after NSLICE shifts.
    assign w_result_next = (r_acc >> STEP) | (WIDTH'(w_slice[STEP-1:0]) << (WIDTH - STEP));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_next = S_RUN;
            S_RUN:   if (w_last)   w_state_next = S_DONE;
            S_DONE:  if (w_ack)    w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.ready_o = (r_state == S_IDLE);
        bus.valid_o = (r_state == S_DONE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_acc       <= '0;
            r_carry     <= 1'b0;
            r_result    <= '0;
            r_carry_out <= 1'b0;
        end else if (w_accept) begin
            r_a     <= bus.a_i;
            r_b     <= bus.sub_i ? ~bus.b_i : bus.b_i;
            r_carry <= bus.sub_i | bus.carry_i;
            r_cnt   <= '0;
            r_acc   <= '0;
        end else if (r_state == S_RUN) begin
            r_a     <= r_a >> STEP;
            r_b     <= r_b >> STEP;
            r_carry <= w_slice[STEP];
            r_acc   <= w_result_next;
            r_cnt   <= r_cnt + CW'(1);
            if (w_last) begin
                r_result    <= w_result_next;
                r_carry_out <= w_slice[STEP];
            end
        end
    end

    assign bus.result_o = r_result;
    assign bus.carry_o  = r_carry_out;

`ifdef SERIAL_ADDSUB_FLAGS_EN
    logic r_zero;
    logic r_overflow;

    // Carry into the MSB is recovered from the MSB sum bit: c_in = a ^ b ^ s.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_zero     <= 1'b0;
            r_overflow <= 1'b0;
        end else if (w_last) begin
            r_zero     <= (w_result_next == '0);
            r_overflow <= w_slice[STEP] ^ (r_a[STEP-1] ^ r_b[STEP-1] ^ w_slice[STEP-1]);
        end
    end

    assign bus.zero_o     = r_zero;
    assign bus.overflow_o = r_overflow;
`endif
endmodule
